// File: rtl/game_clock_ctrl.sv
// game_clock_ctrl: basketball game-time controller.
//
// Sequences the period clock (MM:SS in BCD), the shot clock and the period counter from a
// single system clock. An internal prescaler divides clk down to one game second.
//
// Optional feature macro: SHOT_CLOCK_EN
//   defined   - shot clock counts down, reloads on shot_reset, and on expiry pauses the game
//               and sounds the buzzer until the next shot_reset or start.
//   undefined - shot_bcd reads 8'h00, shot_reset is ignored, buzzer only in BREAK/OVER.
//
// Ports:
//   clk         system clock, rising edge
//   clr         asynchronous active-high reset
//   start       one-cycle pulse: start / resume / begin next period
//   pause       one-cycle pulse: stop the clock
//   shot_reset  one-cycle pulse: reload the shot clock
//   min_bcd     minutes, two BCD digits
//   sec_bcd     seconds, two BCD digits
//   shot_bcd    shot clock, two BCD digits
//   period      current period, 1..NUM_PERIODS
//   running     high while the game clock runs
//   period_end  one-cycle pulse when the period time reaches 00:00
//   game_over   high once the final period has ended
//   buzzer      high between periods, after the game, or on shot-clock expiry

module game_clock_ctrl #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned PERIOD_MIN  = 10,
  parameter int unsigned NUM_PERIODS = 4,
  parameter int unsigned SHOT_SEC    = 24
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       pause,
  input  logic       shot_reset,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] shot_bcd,
  output logic [2:0] period,
  output logic       running,
  output logic       period_end,
  output logic       game_over,
  output logic       buzzer
);

`ifdef SHOT_CLOCK_EN
  localparam bit ShotEn = 1'b1;
`else
  localparam bit ShotEn = 1'b0;
`endif

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [7:0] MinInit  = {4'(PERIOD_MIN / 10), 4'(PERIOD_MIN % 10)};
  localparam logic [7:0] ShotInit = {4'(SHOT_SEC / 10), 4'(SHOT_SEC % 10)};
  // With the shot clock compiled out the counter is held at zero forever.
  localparam logic [7:0] ShotLoad = ShotEn ? ShotInit : 8'h00;
  localparam logic [2:0] LastPeriod = 3'(NUM_PERIODS);

  typedef enum logic [2:0] {StIdle, StRun, StPause, StBreak, StOver} state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [7:0]      min_q, min_d;
  logic [7:0]      sec_q, sec_d;
  logic [7:0]      shot_q, shot_d;
  logic [2:0]      period_q, period_d;
  logic            shot_buzz_q, shot_buzz_d;
  logic            running_q, period_end_q, game_over_q, buzzer_q;
  logic            period_end_d;
  logic            tick;
  logic            shot_reload;
  logic            shot_expire;

  // Two-digit BCD decrement; callers guarantee the value is nonzero.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      return {v[7:4] - 4'd1, 4'd9};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    min_d        = min_q;
    sec_d        = sec_q;
    shot_d       = shot_q;
    period_d     = period_q;
    shot_buzz_d  = shot_buzz_q;
    period_end_d = 1'b0;
    tick         = 1'b0;
    shot_expire  = 1'b0;
    shot_reload  = ShotEn && shot_reset &&
                   (state_q == StIdle || state_q == StRun || state_q == StPause);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (pre_q == PreMax) begin
          tick  = 1'b1;
          pre_d = '0;
          if (sec_q == 8'h00) begin
            if (min_q != 8'h00) begin
              sec_d = 8'h59;
              min_d = bcd_dec(min_q);
            end
          end else begin
            sec_d = bcd_dec(sec_q);
          end
          // A reload on the same edge wins over the decrement.
          if (!shot_reload && shot_q != 8'h00) begin
            shot_d      = bcd_dec(shot_q);
            shot_expire = (shot_q == 8'h01);
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end

        // Period expiry outranks shot expiry, which outranks a pause request.
        if (tick && min_d == 8'h00 && sec_d == 8'h00) begin
          period_end_d = 1'b1;
          state_d      = (period_q < LastPeriod) ? StBreak : StOver;
        end else if (shot_expire) begin
          state_d     = StPause;
          shot_buzz_d = 1'b1;
        end else if (pause) begin
          state_d = StPause;
        end
      end

      StPause: begin
        if (start) begin
          state_d     = StRun;
          shot_buzz_d = 1'b0;
        end
      end

      StBreak: begin
        if (start) begin
          period_d = period_q + 3'd1;
          min_d    = MinInit;
          sec_d    = 8'h00;
          shot_d   = ShotLoad;
          pre_d    = '0;
          state_d  = StRun;
        end
      end

      StOver: begin
        state_d = StOver;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (shot_reload) begin
      shot_d      = ShotLoad;
      shot_buzz_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= StIdle;
      pre_q        <= '0;
      min_q        <= MinInit;
      sec_q        <= 8'h00;
      shot_q       <= ShotLoad;
      period_q     <= 3'd1;
      shot_buzz_q  <= 1'b0;
      running_q    <= 1'b0;
      period_end_q <= 1'b0;
      game_over_q  <= 1'b0;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      shot_q       <= shot_d;
      period_q     <= period_d;
      shot_buzz_q  <= shot_buzz_d;
      running_q    <= (state_d == StRun);
      period_end_q <= period_end_d;
      game_over_q  <= (state_d == StOver);
      buzzer_q     <= (state_d == StBreak) || (state_d == StOver) || shot_buzz_d;
    end
  end

  assign min_bcd    = min_q;
  assign sec_bcd    = sec_q;
  assign shot_bcd   = shot_q;
  assign period     = period_q;
  assign running    = running_q;
  assign period_end = period_end_q;
  assign game_over  = game_over_q;
  assign buzzer     = buzzer_q;

endmodule
